// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_arb_pkg
// Description : Shared types and constants for the SRAM port arbiter.
//               arb_owner_e names which requester owns the SRAM read-data
//               cycle that follows a grant.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } arb_owner_e;

    // Active-low byte write enables: all ones means a read access.
    localparam logic [3:0] WEB_READ = 4'hF;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_prio.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_prio
// Description : Combinational two-way priority pick. DM wins a conflict
//               unless the IF starvation guard has fired.
// Ports       : if_req, dm_req  - qualified requests
//               starve_hit      - IF has been denied the limit number of cycles
//               if_win, dm_win  - one-hot-or-zero winner
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_prio (
    input  logic if_req,
    input  logic dm_req,
    input  logic starve_hit,
    output logic if_win,
    output logic dm_win
);

    always_comb begin
        if_win = 1'b0;
        dm_win = 1'b0;
        if (if_req && dm_req) begin
            if (starve_hit) begin
                if_win = 1'b1;
            end else begin
                dm_win = 1'b1;
            end
        end else if (if_req) begin
            if_win = 1'b1;
        end else if (dm_req) begin
            dm_win = 1'b1;
        end
    end

endmodule : mem_arb_prio
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_arbiter
// Description : Shares one single-port SRAM (1-cycle read latency) between
//               the CPU instruction-fetch (IF) and data-memory (DM) ports.
//               Grants are combinational; read data returns one cycle after
//               the grant, so a new access can issue every cycle.
// Ports       : clk, rst (async, active-low)
//               if_req/if_addr  -> if_gnt, if_rvalid, if_rdata
//               dm_req/dm_web/dm_addr/dm_wdata -> dm_gnt, dm_rvalid, dm_rdata
//               sram_cs/oe/web/a/di -> SRAM, sram_do <- SRAM
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic [3:0]            dm_web,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  sram_cs,
    output logic                  sram_oe,
    output logic [3:0]            sram_web,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_di,
    input  logic [DATA_WIDTH-1:0] sram_do
);

    localparam int                CNT_W        = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  c_STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_owner_e       r_owner;
    arb_owner_e       w_owner_nxt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_cnt_nxt;
    logic             w_starve_hit;
    logic             w_if_win;
    logic             w_dm_win;

    assign w_starve_hit = (r_starve_cnt == c_STARVE_MAX);

    // Requests are masked while reset is asserted so no grant (and no SRAM
    // access) can leak out during the asynchronous reset window.
    mem_arb_prio u_prio (
        .if_req     (if_req & rst),
        .dm_req     (dm_req & rst),
        .starve_hit (w_starve_hit),
        .if_win     (w_if_win),
        .dm_win     (w_dm_win)
    );

    assign if_gnt = w_if_win;
    assign dm_gnt = w_dm_win;

    // SRAM request side: winner steers address/enables in the grant cycle.
    assign sram_cs  = w_if_win | w_dm_win;
    assign sram_web = w_dm_win ? dm_web  : WEB_READ;
    assign sram_a   = w_dm_win ? dm_addr : if_addr;
    assign sram_di  = dm_wdata;

    // Data cycle: the owner captured at the grant edge qualifies sram_do.
    assign if_rvalid = (r_owner == OWN_IF);
    assign dm_rvalid = (r_owner == OWN_DM);
    assign sram_oe   = (r_owner != OWN_NONE);
    assign if_rdata  = sram_do;
    assign dm_rdata  = sram_do;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner      <= OWN_NONE;
            r_starve_cnt <= '0;
        end else begin
            r_owner      <= w_owner_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
        end
    end

    always_comb begin
        w_owner_nxt      = OWN_NONE;
        w_starve_cnt_nxt = r_starve_cnt;

        // DM writes complete at the grant edge and never own a data cycle.
        if (w_if_win) begin
            w_owner_nxt = OWN_IF;
        end else if (w_dm_win && (dm_web == WEB_READ)) begin
            w_owner_nxt = OWN_DM;
        end

        if (!if_req || w_if_win) begin
            w_starve_cnt_nxt = '0;
        end else if (!w_starve_hit) begin
            w_starve_cnt_nxt = r_starve_cnt + 1'b1;
        end
    end

endmodule : sram_port_arbiter
`default_nettype wire
